// File: rtl/reverse_conversion_pkg.sv
// Shared definitions for the unit converters: widths, mode encodings, per-mode
// scale constants and the iteration counts of the sequential datapath.
package reverse_conversion_pkg;

    localparam int WIDTH      = 19;
    localparam int ACC_W      = 26;
    localparam int DIV_W      = 24;
    localparam int K_W        = 7;
    localparam int MUL_CYCLES = 7;
    localparam int DIV_CYCLES = 24;

    localparam logic [3:0] DIVISOR = 4'd12;

    typedef enum logic [1:0] {
        MODE_X100   = 2'b00,
        MODE_X1     = 2'b01,
        MODE_X30    = 2'b10,
        MODE_X30_12 = 2'b11
    } conv_mode_e;

    localparam logic [K_W-1:0] K_X100 = 7'd100;
    localparam logic [K_W-1:0] K_X1   = 7'd1;
    localparam logic [K_W-1:0] K_X30  = 7'd30;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } conv_state_e;

    // Mode 11 multiplies by 30 here and divides by DIVISOR afterwards.
    function automatic logic [K_W-1:0] k_for_mode(input conv_mode_e mode);
        case (mode)
            MODE_X100:   k_for_mode = K_X100;
            MODE_X1:     k_for_mode = K_X1;
            MODE_X30:    k_for_mode = K_X30;
            MODE_X30_12: k_for_mode = K_X30;
            default:     k_for_mode = K_X1;
        endcase
    endfunction

endpackage

// File: rtl/restoring_div24.sv
// Sequential restoring divide of a 24-bit dividend by DIVISOR, one quotient bit
// per cycle MSB first. done flags the cycle in which the final step executes.
module restoring_div24
    import reverse_conversion_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    output logic             done,
    output logic [DIV_W-1:0] quotient
);

    logic [3:0]       rem_r;
    logic [DIV_W-1:0] quot_r;
    logic [4:0]       cnt_r;
    logic             run_r;

    logic [4:0]       trial_s;
    logic [3:0]       rem_next_s;
    logic [DIV_W-1:0] quot_next_s;
    logic             last_s;

    // One restoring step: dividend bits shift out of quot_r, quotient bits shift in.
    always_comb begin
        trial_s     = {rem_r, quot_r[DIV_W-1]};
        rem_next_s  = trial_s[3:0];
        quot_next_s = {quot_r[DIV_W-2:0], 1'b0};
        if (trial_s >= {1'b0, DIVISOR}) begin
            rem_next_s  = 4'(trial_s - {1'b0, DIVISOR});
            quot_next_s = {quot_r[DIV_W-2:0], 1'b1};
        end else begin
            rem_next_s  = trial_s[3:0];
            quot_next_s = {quot_r[DIV_W-2:0], 1'b0};
        end
    end

    assign last_s   = run_r && (cnt_r == 5'(DIV_CYCLES - 1));
    assign done     = last_s;
    assign quotient = quot_r;

    // Load on start, then iterate DIV_CYCLES steps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_r  <= 4'd0;
            quot_r <= {DIV_W{1'b0}};
            cnt_r  <= 5'd0;
            run_r  <= 1'b0;
        end else if (start) begin
            rem_r  <= 4'd0;
            quot_r <= dividend;
            cnt_r  <= 5'd0;
            run_r  <= 1'b1;
        end else if (run_r) begin
            rem_r  <= rem_next_s;
            quot_r <= quot_next_s;
            cnt_r  <= cnt_r + 5'd1;
            if (last_s) begin
                run_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/reverse_conversion.sv
// Rescales a user-unit value back into the raw 19-bit domain using an iterative
// shift-add multiply by K and, for mode 11, a restoring divide by 12.
module reverse_conversion
    import reverse_conversion_pkg::*;
#(
    parameter int WIDTH = reverse_conversion_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       convertFrom,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out,
    output logic             overflow
);

    conv_state_e      state_r;
    conv_state_e      state_next_s;
    conv_mode_e       mode_r;
    logic [WIDTH-1:0] operand_r;
    logic [K_W-1:0]   k_r;
    logic [ACC_W-1:0] acc_r;
    logic [2:0]       bit_cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] data_out_r;
    logic             overflow_r;

    logic [ACC_W-1:0] addend_s;
    logic [ACC_W-1:0] acc_next_s;
    logic             mul_last_s;
    logic             div_start_s;
    logic             div_done_s;
    logic [DIV_W-1:0] div_quot_s;
    logic [ACC_W-1:0] result_s;
    logic             sat_s;

    assign addend_s   = k_r[bit_cnt_r] ? (ACC_W'(operand_r) << bit_cnt_r) : {ACC_W{1'b0}};
    assign acc_next_s = acc_r + addend_s;
    assign mul_last_s = (bit_cnt_r == 3'(MUL_CYCLES - 1));

    // The divider loads the final product on the last multiply edge so its
    // 24 steps line up exactly with the DIV state.
    assign div_start_s = (state_r == ST_MUL) && mul_last_s && (mode_r == MODE_X30_12);

    restoring_div24 u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start_s),
        .dividend (acc_next_s[DIV_W-1:0]),
        .done     (div_done_s),
        .quotient (div_quot_s)
    );

    assign result_s = (mode_r == MODE_X30_12) ? ACC_W'(div_quot_s) : acc_r;
    assign sat_s    = |result_s[ACC_W-1:WIDTH];

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_next_s = ST_MUL;
                else       state_next_s = ST_IDLE;
            end
            ST_MUL: begin
                if (!mul_last_s)                  state_next_s = ST_MUL;
                else if (mode_r == MODE_X30_12)   state_next_s = ST_DIV;
                else                              state_next_s = ST_DONE;
            end
            ST_DIV: begin
                if (div_done_s) state_next_s = ST_DONE;
                else            state_next_s = ST_DIV;
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_next_s;
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r     <= MODE_X100;
            operand_r  <= {WIDTH{1'b0}};
            k_r        <= {K_W{1'b0}};
            acc_r      <= {ACC_W{1'b0}};
            bit_cnt_r  <= 3'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            data_out_r <= {WIDTH{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        mode_r    <= conv_mode_e'(convertFrom);
                        operand_r <= data_in;
                        k_r       <= k_for_mode(conv_mode_e'(convertFrom));
                        acc_r     <= {ACC_W{1'b0}};
                        bit_cnt_r <= 3'd0;
                        busy_r    <= 1'b1;
                    end
                end
                ST_MUL: begin
                    acc_r     <= acc_next_s;
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                end
                ST_DIV: begin
                    bit_cnt_r <= 3'd0;
                end
                ST_DONE: begin
                    done_r     <= 1'b1;
                    busy_r     <= 1'b0;
                    overflow_r <= sat_s;
                    data_out_r <= sat_s ? {WIDTH{1'b1}} : result_s[WIDTH-1:0];
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign data_out = data_out_r;
    assign overflow = overflow_r;

endmodule
